// File: rtl/adpcm_pkg.sv
// -----------------------------------------------------------------------------
// adpcm_pkg
// Purpose : shared constants and state encoding for the ADPCM zero-section
//           predictor (filtez) and its multiply-accumulate datapath.
// Contents:
//   ADPCM_NTAPS, ADPCM_ADDR_W, ADPCM_DATA_W, ADPCM_ACC_W, ADPCM_ZL_SHIFT
//   filtez one-hot state constants S_IDLE / S_RD / S_MAC / S_DONE
//   adpcm_sat32 : clamp a 64-bit signed value into the 32-bit signed range
// -----------------------------------------------------------------------------
package adpcm_pkg;

    localparam int ADPCM_NTAPS    = 6;
    localparam int ADPCM_ADDR_W   = 3;
    localparam int ADPCM_DATA_W   = 32;
    localparam int ADPCM_ACC_W    = 64;
    localparam int ADPCM_ZL_SHIFT = 14;

    // filtez FSM, one-hot.
    localparam int          FILTEZ_ST_W = 4;
    localparam logic [3:0]  S_IDLE = 4'b0001;
    localparam logic [3:0]  S_RD   = 4'b0010;
    localparam logic [3:0]  S_MAC  = 4'b0100;
    localparam logic [3:0]  S_DONE = 4'b1000;

    // Clamp to [-2^31, 2^31-1].
    function automatic logic [31:0] adpcm_sat32(input logic signed [63:0] v);
        logic [31:0] r;
        if (v > 64'sh0000_0000_7FFF_FFFF) begin
            r = 32'h7FFF_FFFF;
        end else if (v < 64'shFFFF_FFFF_8000_0000) begin
            r = 32'h8000_0000;
        end else begin
            r = v[31:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/filtez_mac.sv
// -----------------------------------------------------------------------------
// filtez_mac
// Purpose : registered signed 32x32 multiply-accumulate. The full 64-bit
//           product is added into a 64-bit accumulator that wraps modulo 2^64.
// Ports   :
//   i_clk    clock, rising edge
//   i_rst_n  synchronous active-low reset, clears the accumulator
//   i_clr    clear accumulator (takes priority over i_en)
//   i_en     accumulate i_a * i_b this cycle
//   i_a/i_b  signed operands
//   o_acc    accumulator value (registered)
// -----------------------------------------------------------------------------
module filtez_mac
    import adpcm_pkg::*;
(
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_clr,
    input  logic                           i_en,
    input  logic signed [ADPCM_DATA_W-1:0] i_a,
    input  logic signed [ADPCM_DATA_W-1:0] i_b,
    output logic signed [ADPCM_ACC_W-1:0]  o_acc
);

    logic signed [ADPCM_ACC_W-1:0] r_acc;
    logic signed [ADPCM_ACC_W-1:0] w_a_ext;
    logic signed [ADPCM_ACC_W-1:0] w_b_ext;
    logic signed [ADPCM_ACC_W-1:0] w_prod;

    // Sign-extend both operands first so the product is computed at full
    // 64-bit width; a 32x32 signed product always fits in 64 bits.
    assign w_a_ext = {{(ADPCM_ACC_W-ADPCM_DATA_W){i_a[ADPCM_DATA_W-1]}}, i_a};
    assign w_b_ext = {{(ADPCM_ACC_W-ADPCM_DATA_W){i_b[ADPCM_DATA_W-1]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/filtez.sv
// -----------------------------------------------------------------------------
// filtez
// Purpose : ADPCM zero-section predictor. Computes
//             zl = sum_{i=0..5} bli[i] * dlti[i]
//           and returns zl >>> 14 (low 32 bits). Reads the bli and dlti
//           memories only; never writes them.
// Ports   :
//   ap_clk, ap_rst_n          clock, synchronous active-low reset
//   ap_start/done/idle/ready  block-level handshake
//   bli_address0/ce0/q0       coefficient memory read port (1-cycle latency)
//   dlti_address0/ce0/q0      delayed-difference memory read port
//   ap_return                 registered signed result
//   o_dbg_state               current one-hot FSM state, for observation
// Configuration:
//   FILTEZ_SAT_EN  when defined, the shifted sum is clamped to the signed
//                  32-bit range instead of being truncated.
// Handshake: ap_start is sampled only in S_IDLE; once a run starts it
// completes regardless of ap_start. ap_done and ap_ready pulse together for
// the single S_DONE cycle; ap_return takes the new value at the end of that
// cycle and holds until the next S_DONE or reset. ap_idle is high in S_IDLE
// while ap_start is low.
// -----------------------------------------------------------------------------
module filtez
    import adpcm_pkg::*;
(
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    ap_start,
    output logic                    ap_done,
    output logic                    ap_idle,
    output logic                    ap_ready,
    output logic [ADPCM_ADDR_W-1:0] bli_address0,
    output logic                    bli_ce0,
    input  logic [ADPCM_DATA_W-1:0] bli_q0,
    output logic [ADPCM_ADDR_W-1:0] dlti_address0,
    output logic                    dlti_ce0,
    input  logic [ADPCM_DATA_W-1:0] dlti_q0,
    output logic [ADPCM_DATA_W-1:0] ap_return,
    output logic [FILTEZ_ST_W-1:0]  o_dbg_state
);

    localparam logic [ADPCM_ADDR_W-1:0] LAST_TAP = ADPCM_ADDR_W'(ADPCM_NTAPS - 1);

    logic [FILTEZ_ST_W-1:0]         r_state;
    logic [FILTEZ_ST_W-1:0]         w_state_nxt;
    logic [ADPCM_ADDR_W-1:0]        r_idx;
    logic [ADPCM_DATA_W-1:0]        r_ret;

    logic                           w_in_idle;
    logic                           w_in_rd;
    logic                           w_in_mac;
    logic                           w_in_done;
    logic                           w_launch;
    logic                           w_last_tap;
    logic signed [ADPCM_ACC_W-1:0]  w_acc;
    logic signed [ADPCM_ACC_W-1:0]  w_shifted;
    logic [ADPCM_DATA_W-1:0]        w_result;

    assign w_in_idle  = (r_state == S_IDLE);
    assign w_in_rd    = (r_state == S_RD);
    assign w_in_mac   = (r_state == S_MAC);
    assign w_in_done  = (r_state == S_DONE);
    assign w_launch   = w_in_idle && ap_start;
    assign w_last_tap = (r_idx == LAST_TAP);

    // Next-state logic. Any unexpected encoding falls back to S_IDLE.
    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_nxt = ap_start ? S_RD : S_IDLE;
            S_RD:    w_state_nxt = S_MAC;
            S_MAC:   w_state_nxt = w_last_tap ? S_DONE : S_RD;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Tap index: cleared on launch, advanced after each non-final MAC.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_idx <= '0;
        end else if (w_launch) begin
            r_idx <= '0;
        end else if (w_in_mac && !w_last_tap) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // Read data requested in S_RD arrives during the following S_MAC cycle,
    // so accumulation is enabled in S_MAC only.
    filtez_mac u_mac (
        .i_clk   (ap_clk),
        .i_rst_n (ap_rst_n),
        .i_clr   (w_launch),
        .i_en    (w_in_mac),
        .i_a     (bli_q0),
        .i_b     (dlti_q0),
        .o_acc   (w_acc)
    );

    // Arithmetic shift: negative sums round toward minus infinity.
    assign w_shifted = w_acc >>> ADPCM_ZL_SHIFT;

`ifdef FILTEZ_SAT_EN
    assign w_result = adpcm_sat32(w_shifted);
`else
    assign w_result = w_shifted[ADPCM_DATA_W-1:0];
`endif

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_ret <= '0;
        end else if (w_in_done) begin
            r_ret <= w_result;
        end
    end

    assign ap_return     = r_ret;
    assign ap_done       = w_in_done;
    assign ap_ready      = w_in_done;
    assign ap_idle       = w_in_idle && !ap_start;

    assign bli_ce0       = w_in_rd;
    assign dlti_ce0      = w_in_rd;
    assign bli_address0  = w_in_rd ? r_idx : '0;
    assign dlti_address0 = w_in_rd ? r_idx : '0;

    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_filtez.sv
// -----------------------------------------------------------------------------
// tb_filtez : self-checking bench for filtez. Memories are modelled as arrays
// with a 1-cycle registered read; expected results come from a plain
// arithmetic model of the predictor sum.
// -----------------------------------------------------------------------------
module tb_filtez;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [2:0]  bli_address0;
    logic        bli_ce0;
    logic [31:0] bli_q0;
    logic [2:0]  dlti_address0;
    logic        dlti_ce0;
    logic [31:0] dlti_q0;
    logic [31:0] ap_return;
    logic [3:0]  dbg_state;

    logic signed [31:0] bli_mem  [6];
    logic signed [31:0] dlti_mem [6];

    logic [31:0] exp_q [$];
    logic [2:0]  qb [$];
    logic [2:0]  qd [$];

    int n_checks = 0;
    int n_errors = 0;

    filtez dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .ap_start      (ap_start),
        .ap_done       (ap_done),
        .ap_idle       (ap_idle),
        .ap_ready      (ap_ready),
        .bli_address0  (bli_address0),
        .bli_ce0       (bli_ce0),
        .bli_q0        (bli_q0),
        .dlti_address0 (dlti_address0),
        .dlti_ce0      (dlti_ce0),
        .dlti_q0       (dlti_q0),
        .ap_return     (ap_return),
        .o_dbg_state   (dbg_state)
    );

    // ---------------- clock / memories / monitor ----------------
    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) begin
        if (bli_ce0)  bli_q0  <= bli_mem[bli_address0];
        if (dlti_ce0) dlti_q0 <= dlti_mem[dlti_address0];
    end

    always @(negedge ap_clk) begin
        if (bli_ce0)  qb.push_back(bli_address0);
        if (dlti_ce0) qd.push_back(dlti_address0);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: sum of 64-bit products (wrapping), arithmetic shift by 14.
    function automatic logic [31:0] model_zl();
        longint sum;
        longint sh;
        sum = 0;
        for (int i = 0; i < 6; i++) begin
            sum += longint'(bli_mem[i]) * longint'(dlti_mem[i]);
        end
        sh = sum >>> 14;
`ifdef FILTEZ_SAT_EN
        if (sh > 64'sh0000_0000_7FFF_FFFF) return 32'h7FFF_FFFF;
        if (sh < 64'shFFFF_FFFF_8000_0000) return 32'h8000_0000;
`endif
        return sh[31:0];
    endfunction

    task automatic load(input logic [31:0] b [6], input logic [31:0] d [6]);
        for (int i = 0; i < 6; i++) begin
            bli_mem[i]  = b[i];
            dlti_mem[i] = d[i];
        end
    endtask

    task automatic check_addrs(input int runs);
        check("bli_rd_count", 64'(qb.size()), 64'(6 * runs));
        check("dlti_rd_count", 64'(qd.size()), 64'(6 * runs));
        for (int i = 0; i < 6 * runs; i++) begin
            if (i < qb.size()) check("bli_addr", 64'(qb[i]), 64'(i % 6));
            if (i < qd.size()) check("dlti_addr", 64'(qd[i]), 64'(i % 6));
        end
    endtask

    // One start pulse, from S_IDLE. Checks latency, pulse shape and result.
    task automatic run_once(input string tag, input logic [31:0] exp);
        int cyc;
        qb.delete();
        qd.delete();
        exp_q.push_back(exp);
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        cyc = 1;
        while (!ap_done && cyc < 40) begin
            @(posedge ap_clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd13);
        check({tag, "_ready"}, 64'(ap_ready), 64'd1);
        @(posedge ap_clk); #1;
        check({tag, "_done_pulse"}, 64'(ap_done), 64'd0);
        check({tag, "_idle"}, 64'(ap_idle), 64'd1);
        check({tag, "_return"}, 64'(ap_return), 64'(exp_q.pop_front()));
        check_addrs(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] b [6];
        logic [31:0] d [6];
        logic [31:0] exp_v;
        int          done_k [$];
        int          mode;
        logic        prev_done;

        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bli_mem[i] = '0;
            dlti_mem[i] = '0;
        end
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_return", 64'(ap_return), 64'd0);
        check("rst_done", 64'(ap_done), 64'd0);
        check("rst_ready", 64'(ap_ready), 64'd0);
        check("rst_bli_ce", 64'(bli_ce0), 64'd0);
        check("rst_dlti_ce", 64'(dlti_ce0), 64'd0);
        check("rst_addr", 64'({bli_address0, dlti_address0}), 64'd0);
        check("rst_idle", 64'(ap_idle), 64'd1);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        check("post_rst_idle", 64'(ap_idle), 64'd1);

        // Ramp: 16384 * (1+..+6) = 21 << 14.
        for (int i = 0; i < 6; i++) begin
            b[i] = 32'd16384;
            d[i] = 32'(i + 1);
        end
        load(b, d);
        run_once("ramp", 32'd21);

        for (int i = 0; i < 6; i++) begin
            b[i] = -32'sd16384;
            d[i] = 32'd1;
        end
        load(b, d);
        run_once("neg", 32'hFFFF_FFFA);

        for (int i = 0; i < 6; i++) begin
            b[i] = '0;
            d[i] = '0;
        end
        b[0] = 32'd1;
        d[0] = 32'd16383;
        load(b, d);
        run_once("round_pos", 32'd0);
        b[0] = 32'hFFFF_FFFF;
        d[0] = 32'd1;
        load(b, d);
        run_once("round_neg", 32'hFFFF_FFFF);

        for (int i = 0; i < 6; i++) begin
            b[i] = 32'h4000_0000;
            d[i] = 32'h4000_0000;
        end
        load(b, d);
`ifdef FILTEZ_SAT_EN
        run_once("ovf", 32'h7FFF_FFFF);
`else
        run_once("ovf", 32'h0000_0000);
`endif

        // Random runs against the model.
        for (int n = 0; n < 20; n++) begin
            mode = $urandom_range(0, 2);
            for (int i = 0; i < 6; i++) begin
                case (mode)
                    0: begin
                        bli_mem[i]  = $urandom;
                        dlti_mem[i] = $urandom;
                    end
                    1: begin
                        bli_mem[i]  = 32'($urandom_range(0, 65535)) - 32'd32768;
                        dlti_mem[i] = 32'($urandom_range(0, 65535)) - 32'd32768;
                    end
                    default: begin
                        bli_mem[i]  = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        dlti_mem[i] = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    end
                endcase
            end
            run_once("rand", model_zl());
        end

        // Reset during S_MAC of tap 3; previous ap_return is left from above.
        for (int i = 0; i < 6; i++) begin
            b[i] = 32'd16384;
            d[i] = 32'(i + 1);
        end
        load(b, d);
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        repeat (7) @(posedge ap_clk);
        #1;
        check("mid_state_mac", 64'(dbg_state), 64'b0100);
        ap_rst_n = 1'b0;
        @(posedge ap_clk); #1;
        check("mid_rst_done", 64'(ap_done), 64'd0);
        check("mid_rst_return", 64'(ap_return), 64'd0);
        ap_rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(posedge ap_clk); #1;
            if (ap_done) check("mid_rst_spurious_done", 64'(ap_done), 64'd0);
        end
        check("mid_rst_idle", 64'(ap_idle), 64'd1);
        check("mid_rst_return_hold", 64'(ap_return), 64'd0);
        for (int i = 0; i < 6; i++) begin
            b[i] = 32'd16384 * 32'(i + 2);
            d[i] = 32'(7 - i);
        end
        load(b, d);
        run_once("after_rst", model_zl());

        // ap_start held high for 40 cycles: three back-to-back runs.
        for (int i = 0; i < 6; i++) begin
            bli_mem[i]  = $urandom;
            dlti_mem[i] = $urandom;
        end
        exp_v = model_zl();
        qb.delete();
        qd.delete();
        prev_done = 1'b0;
        ap_start = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(posedge ap_clk); #1;
            if (k == 40) ap_start = 1'b0;
            if (prev_done) check("held_return", 64'(ap_return), 64'(exp_v));
            if (ap_done) done_k.push_back(k);
            prev_done = ap_done;
        end
        check("held_done_count", 64'(done_k.size()), 64'd3);
        for (int j = 0; j < 3; j++) begin
            if (j < done_k.size()) check("held_done_cycle", 64'(done_k[j]), 64'(13 + 14 * j));
        end
        check_addrs(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/filtez.md
Name: filtez

Overview:
- ADPCM zero-section predictor: computes zl = sum over six taps of bli[i]*dlti[i], then returns zl >>> 14.
- Sits directly upstream of upzero in the encoder/decoder loop. It reads the same coefficient memory (bli) and delayed-difference memory (dlti) that upzero updates afterwards.
- Read-only against both memories. Uses the standard ap_start/ap_done/ap_idle/ap_ready block-level handshake.

Parameters:
- NTAPS, 6, number of predictor taps; the loop index runs 0..NTAPS-1.
- ADDR_W, 3, memory address width.
- DATA_W, 32, signed width of memory words and of ap_return.
- ACC_W, 64, signed accumulator width.
- SHIFT, 14, arithmetic right shift applied to the final sum.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst_n  in  1  reset, synchronous, active-low.
- ap_start  in  1  start request.
- ap_done  out  1  one-cycle pulse; ap_return is valid.
- ap_idle  out  1  block is idle.
- ap_ready  out  1  block can accept a new start; high in the same cycle as ap_done.
- bli_address0  out  ADDR_W  coefficient read address.
- bli_ce0  out  1  coefficient read enable.
- bli_q0  in  DATA_W  coefficient read data; signed; 1-cycle read latency.
- dlti_address0  out  ADDR_W  delayed-difference read address.
- dlti_ce0  out  1  delayed-difference read enable.
- dlti_q0  in  DATA_W  delayed-difference read data; signed; 1-cycle read latency.
- ap_return  out  DATA_W  registered result; signed.

Behaviour:
- Interface: one clock, ap_clk. Reset ap_rst_n is synchronous and active-low.
- Reset values:
  - FSM = S_IDLE.
  - Tap index i = 0; accumulator acc = 0.
  - ap_return = 0.
  - ap_done, ap_ready, bli_ce0, dlti_ce0 = 0.
  - Addresses = 0.
- FSM is one-hot with four states:
  - S_IDLE: ap_idle = ap_start==0. When ap_start==1: i<=0, acc<=0, go to S_RD.
  - S_RD: bli_ce0 = dlti_ce0 = 1; bli_address0 = dlti_address0 = i. Go to S_MAC.
  - S_MAC: acc <= acc + sext(bli_q0)*sext(dlti_q0), full 64-bit signed product. If i==NTAPS-1, go to S_DONE; else i<=i+1 and go to S_RD.
  - S_DONE: ap_done = ap_ready = 1 for exactly one cycle. ap_return <= acc >>> SHIFT, low DATA_W bits (truncating, same as a C int cast). Go to S_IDLE.
- Because ap_return is registered at the S_DONE edge, it updates on the cycle after the ap_done pulse. It holds until the next S_DONE or reset.
- Enables and addresses are combinational from the state. Addresses are don't-care while ce is 0 and are driven as 0.
- Latency: ap_start sampled in S_IDLE at cycle T gives ap_done at cycle T+13 (1 + 2*NTAPS).
- Arithmetic:
  - acc wraps modulo 2^64 with no overflow detection.
  - The shift is arithmetic, so negative sums round toward minus infinity.
- Boundary conditions:
  - ap_start dropped mid-operation: ignored; the run completes.
  - ap_start held high through S_DONE: the next run begins only after one S_IDLE cycle, so back-to-back runs have a period of 14 cycles.
  - Reset during any state: returns to S_IDLE next cycle, no ap_done pulse, ap_return = 0.
  - No memory writes occur in any state; there are no write ports.

Optional Feature:
- Macro FILTEZ_SAT_EN.
- Defined: in S_DONE, acc >>> SHIFT is clamped to [-2^31, 2^31-1] before being registered into ap_return.
- Undefined: plain truncation to the low 32 bits.
- Latency is identical in both builds.

Decomposition:
- Shared package adpcm_pkg holds:
  - constants ADPCM_NTAPS=6, ADPCM_ADDR_W=3, ADPCM_DATA_W=32, ADPCM_ACC_W=64, ADPCM_ZL_SHIFT=14;
  - filtez state encoding (S_IDLE, S_RD, S_MAC, S_DONE).
- One sub-module, filtez_mac: registered signed 32x32 multiply-accumulate with clear and enable inputs, exposing acc. The top level owns the FSM, address counter and result/saturation logic.

Test Plan:
- bli[i]=16384, dlti[i]=i+1 for i=0..5; pulse ap_start -> ap_done at T+13, ap_return=21, ap_idle back to 1 next cycle.
- bli[i]=-16384, dlti[i]=1 for all taps -> ap_return=-6 (0xFFFFFFFA).
- Rounding: only tap 0 nonzero. bli=1, dlti=16383 -> ap_return=0. bli=-1, dlti=1 -> ap_return=-1.
- Overflow: bli[i]=dlti[i]=2^30 for all six taps -> ap_return=0x00000000 without FILTEZ_SAT_EN, 0x7FFFFFFF with it.
- Reset mid-run: drive ap_rst_n=0 during S_MAC of tap 3 -> no ap_done, ap_return=0, ap_idle=1 after release. A fresh run then gives the correct result.
- ap_start held high for 40 cycles -> ap_done pulses at T+13, T+27 and T+41, result identical each run. bli_ce0/dlti_ce0 are high only in S_RD, with addresses 0..5 in order.
